// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Purpose  : Direct-mapped, 8-line, one-word-per-line data cache sitting
//            between a CPU memory stage and a single-port backing memory.
//            Write-through, no-write-allocate, with saturating read-hit and
//            read-miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] addr,
  input  logic [9:0] wdata,
  input  logic       rd_en,
  input  logic       wr_en,
  output logic [9:0] rdata,
  output logic       cache_Ready,
  output logic [9:0] mem_addr,
  output logic [9:0] mem_wdata,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic [9:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  state_t      state;
  logic [7:0]  valid;
  logic [6:0]  tag_mem  [8];
  logic [9:0]  data_mem [8];

  logic [2:0]  index;
  logic [6:0]  tag;
  logic        hit;
  logic        fill;
  logic        store_update;

  assign index = addr[2:0];
  assign tag   = addr[9:3];

  // Valid bits gate every hit, so the tag/data arrays never need clearing.
  assign hit = valid[index] && (tag_mem[index] == tag);

  // Line writes only happen on the ack cycle of a live transaction; an async
  // reset forces IDLE, so an aborted transaction can never update a line.
  assign fill         = (state == RD_MISS) && mem_ack;
  assign store_update = (state == WR_THRU) && mem_ack && hit;

  // The CPU holds addr/wdata stable until cache_Ready, so memory can follow them directly.
  assign mem_addr  = addr;
  assign mem_wdata = wdata;

  // Control FSM, memory strobes and saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      valid    <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A store takes priority over a simultaneous load request.
          if (wr_en) begin
            state  <= WR_THRU;
            mem_wr <= 1'b1;
          end else if (rd_en) begin
            if (hit) begin
              if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 8'd1;
            end else begin
              state  <= RD_MISS;
              mem_rd <= 1'b1;
              if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 8'd1;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            valid[index] <= 1'b1;
            mem_rd       <= 1'b0;
            state        <= IDLE;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage: refilled on a read-miss ack, patched on a store hit.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= mem_rdata;
    end else if (store_update) begin
      data_mem[index] <= wdata;
    end
  end

  // CPU-side handshake: hits and ack cycles complete in the same cycle.
  always_comb begin
    cache_Ready = 1'b1;
    rdata       = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            cache_Ready = 1'b0;
          end else if (rd_en) begin
            cache_Ready = hit;
            if (hit) rdata = data_mem[index];
          end
        end
        RD_MISS: begin
          cache_Ready = mem_ack;
          if (mem_ack && rd_en) rdata = mem_rdata;
        end
        WR_THRU: begin
          cache_Ready = mem_ack;
        end
        default: begin
          cache_Ready = 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
